// File: rtl/canon_sequencer.sv
// canon_sequencer: two-voice step sequencer that plays note pairs from a
// step RAM, decoding each note into a PWM divider and a gated voice enable.
module canon_sequencer #(
  parameter int SEQ_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [4:0]  last_step,
  input  logic [23:0] tempo_div,
  input  logic [23:0] gap_len,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [5:0]  wr_note1,
  input  logic [5:0]  wr_note2,
  output logic [11:0] divider1,
  output logic [11:0] divider2,
  output logic        gate1,
  output logic        gate2,
  output logic [4:0]  step,
  output logic        playing,
  output logic        step_tick
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PLAY
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(SEQ_LEN - 1);

  state_t      state, state_d;
  logic [4:0]  step_d;
  logic [23:0] cnt, cnt_d;
  logic [11:0] div1_d, div2_d;
  logic        act1, act2, act1_d, act2_d;
  logic        gate1_d, gate2_d, tick_d, playing_d;

  logic [11:0] mem [SEQ_LEN];
  logic [11:0] rd;
  logic [12:0] dec1, dec2;
  logic [4:0]  last_eff, step_inc;

  // {non_rest, divider}; divider is only meaningful when non_rest is set
  function automatic logic [12:0] decode(input logic [5:0] n);
    logic [5:0]  idx;
    logic [5:0]  oct;
    logic [3:0]  semi;
    logic [11:0] base;
    logic [12:0] res;
    idx  = n - 6'd1;
    oct  = idx / 6'd12;
    semi = 4'(idx % 6'd12);
    case (semi)
      4'd0:    base = 12'd93;
      4'd1:    base = 12'd88;
      4'd2:    base = 12'd83;
      4'd3:    base = 12'd79;
      4'd4:    base = 12'd74;
      4'd5:    base = 12'd70;
      4'd6:    base = 12'd66;
      4'd7:    base = 12'd62;
      4'd8:    base = 12'd59;
      4'd9:    base = 12'd56;
      4'd10:   base = 12'd52;
      4'd11:   base = 12'd49;
      default: base = 12'd0;
    endcase
    res = 13'd0;
    if (n != 6'd0 && n <= 6'd60) begin
      res[11:0] = (base << (3'd4 - oct[2:0])) - 12'd1;
      res[12]   = 1'b1;
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst && wr_en && {27'd0, wr_addr} < 32'(SEQ_LEN))
      mem[wr_addr] <= {wr_note1, wr_note2};
  end

  // write-first bypass so a same-cycle write reaches the fetch
  assign rd = (wr_en && wr_addr == step) ?
              {wr_note1, wr_note2} : mem[step];

  assign dec1 = decode(rd[11:6]);
  assign dec2 = decode(rd[5:0]);

  assign last_eff = ({27'd0, last_step} >= 32'(SEQ_LEN)) ?
                    LAST_IDX : last_step;
  assign step_inc = (step >= LAST_IDX) ? 5'd0 : step + 5'd1;

  always_comb begin
    state_d = state;
    step_d  = step;
    cnt_d   = cnt;
    div1_d  = divider1;
    div2_d  = divider2;
    act1_d  = act1;
    act2_d  = act2;
    if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_d = FETCH;
            step_d  = 5'd0;
          end
        end
        FETCH: begin
          state_d = PLAY;
          cnt_d   = tempo_div;
          act1_d  = dec1[12];
          act2_d  = dec2[12];
          if (dec1[12]) div1_d = dec1[11:0];
          if (dec2[12]) div2_d = dec2[11:0];
        end
        PLAY: begin
          if (cnt != 24'd0) begin
            cnt_d = cnt - 24'd1;
          end else if (step == last_eff && !loop_en) begin
            state_d = IDLE;
          end else begin
            state_d = FETCH;
            step_d  = (step == last_eff) ? 5'd0 : step_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    gate1_d   = (state_d == PLAY) && act1_d && (cnt_d > gap_len);
    gate2_d   = (state_d == PLAY) && act2_d && (cnt_d > gap_len);
    tick_d    = (state == FETCH) && !stop;
    playing_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= 5'd0;
      cnt       <= 24'd0;
      divider1  <= 12'd0;
      divider2  <= 12'd0;
      act1      <= 1'b0;
      act2      <= 1'b0;
      gate1     <= 1'b0;
      gate2     <= 1'b0;
      playing   <= 1'b0;
      step_tick <= 1'b0;
    end else begin
      state     <= state_d;
      step      <= step_d;
      cnt       <= cnt_d;
      divider1  <= div1_d;
      divider2  <= div2_d;
      act1      <= act1_d;
      act2      <= act2_d;
      gate1     <= gate1_d;
      gate2     <= gate2_d;
      playing   <= playing_d;
      step_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_canon_sequencer.sv
// tb_canon_sequencer: directed scenario tests for canon_sequencer
// with hand-computed expected dividers, gates and step timing.
module tb_canon_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [4:0]  last_step = 5'd0;
  logic [23:0] tempo_div = 24'd0;
  logic [23:0] gap_len = 24'd0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [5:0]  wr_note1 = 6'd0;
  logic [5:0]  wr_note2 = 6'd0;
  logic [11:0] divider1, divider2;
  logic        gate1, gate2;
  logic [4:0]  step;
  logic        playing, step_tick;

  int checks = 0;
  int errors = 0;

  canon_sequencer #(.SEQ_LEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .loop_en(loop_en), .last_step(last_step),
    .tempo_div(tempo_div), .gap_len(gap_len),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_note1(wr_note1), .wr_note2(wr_note2),
    .divider1(divider1), .divider2(divider2),
    .gate1(gate1), .gate2(gate2), .step(step),
    .playing(playing), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr_ram(input logic [4:0] a, input logic [5:0] n1,
                        input logic [5:0] n2);
    wr_en = 1'b1; wr_addr = a; wr_note1 = n1; wr_note2 = n2;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (divider1 !== 12'd0) begin errors++; $display("FAIL reset_div1: got %0d expected 0", divider1); end
    checks++; if (divider2 !== 12'd0) begin errors++; $display("FAIL reset_div2: got %0d expected 0", divider2); end
    checks++; if ({gate1, gate2, playing, step_tick} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {gate1, gate2, playing, step_tick}); end
    checks++; if (step !== 5'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
  endtask

  task automatic test_basic();
    int hi1, hi2, per;
    bit found;
    do_reset();
    wr_ram(5'd0, 6'd10, 6'd22);
    tempo_div = 24'd9; gap_len = 24'd2; loop_en = 1'b1; last_step = 5'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (playing !== 1'b1 || step_tick !== 1'b0 || gate1 !== 1'b0) begin errors++; $display("FAIL basic_fetch: got play=%b tick=%b g1=%b expected 1 0 0", playing, step_tick, gate1); end
    @(negedge clk);
    checks++; if (divider1 !== 12'd895) begin errors++; $display("FAIL basic_div1: got %0d expected 895", divider1); end
    checks++; if (divider2 !== 12'd447) begin errors++; $display("FAIL basic_div2: got %0d expected 447", divider2); end
    checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL basic_tick: got %b expected 1", step_tick); end
    hi1 = 0; hi2 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      hi1 += int'(gate1);
      hi2 += int'(gate2);
    end
    checks++; if (hi1 !== 7) begin errors++; $display("FAIL basic_gate1_hi: got %0d expected 7", hi1); end
    checks++; if (hi2 !== 7) begin errors++; $display("FAIL basic_gate2_hi: got %0d expected 7", hi2); end
    per = 9; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      per++;
      if (step_tick) found = 1'b1;
    end
    checks++; if (!found || per !== 11) begin errors++; $display("FAIL basic_period: got %0d found=%b expected 11", per, found); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if ({playing, gate1, gate2} !== 3'b000) begin errors++; $display("FAIL basic_stop_flags: got %b expected 000", {playing, gate1, gate2}); end
    checks++; if (divider1 !== 12'd895 || divider2 !== 12'd447) begin errors++; $display("FAIL basic_stop_div: got %0d %0d expected 895 447", divider1, divider2); end
  endtask

  task automatic test_halt();
    int ticks;
    logic [4:0] es;
    logic ep;
    do_reset();
    last_step = 5'd3; loop_en = 1'b0; tempo_div = 24'd0; gap_len = 24'd0;
    start = 1'b1;
    ticks = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      start = 1'b0;
      es = (i <= 8) ? 5'((i - 1) / 2) : 5'd3;
      ep = (i <= 8);
      ticks += int'(step_tick);
      checks++; if (step !== es) begin errors++; $display("FAIL halt_step[%0d]: got %0d expected %0d", i, step, es); end
      checks++; if (playing !== ep) begin errors++; $display("FAIL halt_playing[%0d]: got %b expected %b", i, playing, ep); end
    end
    checks++; if (ticks !== 4) begin errors++; $display("FAIL halt_ticks: got %0d expected 4", ticks); end
  endtask

  task automatic test_loop_stop();
    logic [4:0] es;
    do_reset();
    wr_ram(5'd1, 6'd1, 6'd60);
    last_step = 5'd1; loop_en = 1'b1; tempo_div = 24'd3; gap_len = 24'd0;
    start = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      start = (i == 3);
      es = 5'(((i - 1) / 5) % 2);
      checks++; if (step !== es) begin errors++; $display("FAIL loop_step[%0d]: got %0d expected %0d", i, step, es); end
      if (i == 7) begin
        checks++; if (divider1 !== 12'd1487 || divider2 !== 12'd48) begin errors++; $display("FAIL loop_div: got %0d %0d expected 1487 48", divider1, divider2); end
      end
      if (i == 13) begin
        checks++; if (gate1 !== 1'b1) begin errors++; $display("FAIL loop_gate: got %b expected 1", gate1); end
      end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if ({playing, gate1, gate2} !== 3'b000) begin errors++; $display("FAIL loop_stop_flags: got %b expected 000", {playing, gate1, gate2}); end
    checks++; if (divider1 !== 12'd895 || step !== 5'd0) begin errors++; $display("FAIL loop_stop_hold: got div=%0d step=%0d expected 895 0", divider1, step); end
  endtask

  task automatic test_rest();
    do_reset();
    wr_ram(5'd2, 6'd0, 6'd63);
    last_step = 5'd2; loop_en = 1'b0; tempo_div = 24'd2; gap_len = 24'd0;
    start = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 6) begin
        checks++; if (gate1 !== 1'b1 || gate2 !== 1'b1) begin errors++; $display("FAIL rest_prev_gate: got %b%b expected 11", gate1, gate2); end
      end
      if (i >= 10 && i <= 12) begin
        checks++; if (gate1 !== 1'b0 || gate2 !== 1'b0) begin errors++; $display("FAIL rest_gate[%0d]: got %b%b expected 00", i, gate1, gate2); end
        checks++; if (divider1 !== 12'd1487 || divider2 !== 12'd48) begin errors++; $display("FAIL rest_div[%0d]: got %0d %0d expected 1487 48", i, divider1, divider2); end
      end
      if (i == 13) begin
        checks++; if (playing !== 1'b0) begin errors++; $display("FAIL rest_idle: got %b expected 0", playing); end
      end
    end
  endtask

  task automatic test_live_write();
    do_reset();
    last_step = 5'd1; loop_en = 1'b0; tempo_div = 24'd2; gap_len = 24'd0;
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (i == 3) begin
        wr_en = 1'b1; wr_addr = 5'd1; wr_note1 = 6'd13; wr_note2 = 6'd25;
      end
      if (i == 6) begin
        checks++; if (divider1 !== 12'd743 || divider2 !== 12'd371) begin errors++; $display("FAIL live_play_write: got %0d %0d expected 743 371", divider1, divider2); end
      end
    end
    do_reset();
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 6) begin
        checks++; if (divider1 !== 12'd48 || divider2 !== 12'd1487) begin errors++; $display("FAIL live_fetch_write: got %0d %0d expected 48 1487", divider1, divider2); end
      end
      wr_en = 1'b0;
      if (i == 5) begin
        wr_en = 1'b1; wr_addr = 5'd1; wr_note1 = 6'd60; wr_note2 = 6'd1;
      end
    end
  endtask

  task automatic test_start_stop();
    do_reset();
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++; if (playing !== 1'b0 || step_tick !== 1'b0) begin errors++; $display("FAIL both_idle: got play=%b tick=%b expected 0 0", playing, step_tick); end
    @(negedge clk);
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL both_idle2: got %b expected 0", playing); end
    last_step = 5'd0; loop_en = 1'b1; tempo_div = 24'd5; gap_len = 24'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd0; wr_note1 = 6'd60; wr_note2 = 6'd60;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    checks++; if (divider1 !== 12'd0 || divider2 !== 12'd0) begin errors++; $display("FAIL rst_mid_div: got %0d %0d expected 0 0", divider1, divider2); end
    checks++; if ({gate1, gate2, playing, step_tick} !== 4'b0 || step !== 5'd0) begin errors++; $display("FAIL rst_mid_flags: got %b step=%0d expected 0000 0", {gate1, gate2, playing, step_tick}, step); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (divider1 !== 12'd895) begin errors++; $display("FAIL rst_blocks_write: got %0d expected 895", divider1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_halt();
    test_loop_stop();
    test_rest();
    test_live_write();
    test_start_stop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
